// File: rtl/freelist_ckpt_pkg.sv
// Default geometry for the tag freelist, shared by rename, ROB and IQ instances
// so they all agree on tag and checkpoint-id widths.
package freelist_ckpt_pkg;

  localparam int unsigned DefFreeNum = 64;
  localparam int unsigned DefFreeSel = 6;
  localparam int unsigned DefAllocW  = 2;
  localparam int unsigned DefRelW    = 3;
  localparam int unsigned DefCkptNum = 4;
  localparam int unsigned DefCkptSel = 2;

endpackage

// File: rtl/freelist_pick.sv
// Multi-hot priority picker: returns the ALLOC_W lowest set indices of vec,
// in ascending order, each with its own valid bit.
module freelist_pick #(
  parameter int unsigned FREE_NUM = 64,
  parameter int unsigned ALLOC_W  = 2,
  localparam int unsigned SelW    = (FREE_NUM > 1) ? $clog2(FREE_NUM) : 1
) (
  input  logic [FREE_NUM-1:0]          vec,
  output logic [ALLOC_W-1:0][SelW-1:0] idx,
  output logic [ALLOC_W-1:0]           vld
);

  logic [FREE_NUM-1:0] avail;

  always_comb begin
    avail = vec;
    idx   = '0;
    vld   = '0;
    for (int k = 0; k < int'(ALLOC_W); k++) begin
      // Descending scan so the last hit, which wins, is the lowest set index.
      for (int i = int'(FREE_NUM) - 1; i >= 0; i--) begin
        if (avail[i]) begin
          idx[k] = SelW'(i);
          vld[k] = 1'b1;
        end
      end
      if (vld[k]) begin
        avail[idx[k]] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/freelist_ckpt.sv
// Multi-lane free-tag allocator with per-branch snapshots of the free vector,
// restored on misprediction recovery.
module freelist_ckpt
  import freelist_ckpt_pkg::*;
#(
  parameter int unsigned FREE_NUM = DefFreeNum,
  parameter int unsigned FREE_SEL = DefFreeSel,
  parameter int unsigned ALLOC_W  = DefAllocW,
  parameter int unsigned REL_W    = DefRelW,
  parameter int unsigned CKPT_NUM = DefCkptNum,
  parameter int unsigned CKPT_SEL = DefCkptSel
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [ALLOC_W-1:0]          req,
  input  logic                        stall,
  output logic [ALLOC_W*FREE_SEL-1:0] alloc_tag,
  output logic [ALLOC_W-1:0]          alloc_valid,
  output logic                        allocatable,
  input  logic [REL_W*FREE_SEL-1:0]   rel_tag,
  input  logic [REL_W-1:0]            rel_valid,
  input  logic                        ckpt_take,
  input  logic [CKPT_SEL-1:0]         ckpt_id,
  input  logic                        prmiss,
  input  logic [CKPT_SEL-1:0]         prmiss_id,
  output logic [FREE_SEL:0]           free_count
);

  localparam int unsigned CntW = FREE_SEL + 1;

  logic [FREE_NUM-1:0]              free_q, free_d;
  logic [FREE_NUM-1:0]              grant_mask, rel_mask;
  logic [FREE_NUM-1:0]              snap_q [CKPT_NUM];
  logic [FREE_NUM-1:0]              snap_d [CKPT_NUM];
  logic [CntW-1:0]                  free_count_q, free_count_d, req_num;
  logic [ALLOC_W-1:0][FREE_SEL-1:0] pick_idx;
  logic [ALLOC_W-1:0]               pick_vld;
  logic                             grant_en, take_en;

  freelist_pick #(
    .FREE_NUM (FREE_NUM),
    .ALLOC_W  (ALLOC_W)
  ) u_pick (
    .vec (free_q),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  always_comb begin
    req_num = '0;
    for (int k = 0; k < int'(ALLOC_W); k++) begin
      req_num = req_num + CntW'(req[k]);
    end
  end

  assign allocatable = (free_count_q >= req_num);
  assign grant_en    = allocatable && !stall && !prmiss;
  assign take_en     = ckpt_take && !stall && !prmiss;

  // Requesting lanes consume picks in lane order, so lane k takes the pick
  // numbered by how many older lanes also requested.
  always_comb begin
    int slot;
    slot        = 0;
    alloc_tag   = '0;
    alloc_valid = '0;
    grant_mask  = '0;
    for (int k = 0; k < int'(ALLOC_W); k++) begin
      if (req[k]) begin
        for (int p = 0; p < int'(ALLOC_W); p++) begin
          if (p == slot && grant_en && pick_vld[p]) begin
            alloc_tag[k*FREE_SEL +: FREE_SEL] = pick_idx[p];
            alloc_valid[k]                    = 1'b1;
            grant_mask[pick_idx[p]]           = 1'b1;
          end
        end
        slot++;
      end
    end
  end

  always_comb begin
    rel_mask = '0;
    for (int r = 0; r < int'(REL_W); r++) begin
      if (rel_valid[r]) begin
        rel_mask[rel_tag[r*FREE_SEL +: FREE_SEL]] = 1'b1;
      end
    end
  end

  always_comb begin
    free_d = prmiss ? (snap_q[prmiss_id] | rel_mask) : ((free_q & ~grant_mask) | rel_mask);
    // Committed releases belong to older instructions, so every live snapshot absorbs them.
    for (int j = 0; j < int'(CKPT_NUM); j++) begin
      snap_d[j] = (take_en && ckpt_id == CKPT_SEL'(j)) ? free_d : (snap_q[j] | rel_mask);
    end
    free_count_d = '0;
    for (int i = 0; i < int'(FREE_NUM); i++) begin
      free_count_d = free_count_d + CntW'(free_d[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      free_q       <= '1;
      free_count_q <= CntW'(FREE_NUM);
      for (int j = 0; j < int'(CKPT_NUM); j++) begin
        snap_q[j] <= '1;
      end
    end else begin
      free_q       <= free_d;
      free_count_q <= free_count_d;
      for (int j = 0; j < int'(CKPT_NUM); j++) begin
        snap_q[j] <= snap_d[j];
      end
    end
  end

  assign free_count = free_count_q;

endmodule
